// File: rtl/spi_mfrc522_pkg.sv
// Shared FSM encoding, frame constants and address-byte helper
// for the MFRC522-style SPI master.
package spi_mfrc522_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } spi_state_t;

   localparam int WR_BYTES = 2;
   localparam int RD_BYTES = 3;
   localparam logic [7:0] DUMMY_BYTE = 8'h00;

   function automatic logic [7:0] addr_byte(
      input logic [6:0] addr,
      input logic       rw
   );
      return {addr, rw};
   endfunction

endpackage

// File: rtl/spi_mfrc522_master_sck_gen.sv
// SCK divider: half-period of CLK_DIV cycles, low half first,
// with one-cycle strobes marking the edge at which SCK toggles.
module spi_sck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic axi_aclk,
   input  logic axi_areset,
   input  logic en,
   output logic sck_rise,
   output logic sck_fall,
   output logic spi_sck
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;
   logic          wrap;

   assign wrap     = en && (div_cnt == LAST);
   assign sck_rise = wrap && !spi_sck;
   assign sck_fall = wrap && spi_sck;

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         div_cnt <= '0;
         spi_sck <= 1'b0;
      end else if (!en) begin
         div_cnt <= '0;
         spi_sck <= 1'b0;
      end else if (wrap) begin
         div_cnt <= '0;
         spi_sck <= !spi_sck;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/spi_mfrc522_master.sv
// Mode 0 SPI master turning register commands into MFRC522 frames.
// Optional SPI_MFRC522_TXN_COUNT_EN builds the completed-frame counter.
module spi_mfrc522_master
   import spi_mfrc522_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 4
) (
   input  logic        axi_aclk,
   input  logic        axi_areset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rw,
   input  logic [6:0]  cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        busy,
   output logic [15:0] txn_count,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int SETUP_N = (CS_SETUP > 1) ? CS_SETUP : 1;
   localparam int HOLD_N  = (CS_HOLD > 1) ? CS_HOLD : 1;
   localparam int IDLE_N  = (CS_IDLE > 1) ? CS_IDLE : 1;
   localparam logic [15:0] SETUP_LAST = 16'(SETUP_N - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(HOLD_N - 1);
   localparam logic [15:0] IDLE_LAST  = 16'(IDLE_N - 1);

   spi_state_t  state, state_d;
   logic [15:0] tmr;
   logic [7:0]  tx_sr, rx_sr, wdata_q;
   logic        rw_q;
   logic [2:0]  bit_cnt;
   logic [1:0]  byte_cnt, last_byte;
   logic        sck_rise, sck_fall, frame_end;

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck (
      .axi_aclk   (axi_aclk),
      .axi_areset (axi_areset),
      .en         (state == ST_SHIFT),
      .sck_rise   (sck_rise),
      .sck_fall   (sck_fall),
      .spi_sck    (spi_sck)
   );

   assign last_byte = rw_q ? 2'(RD_BYTES - 1) : 2'(WR_BYTES - 1);
   assign frame_end = sck_fall && (bit_cnt == 3'd7) && (byte_cnt == last_byte);

   always_comb begin
      state_d = state;
      unique case (state)
         ST_IDLE:  if (cmd_valid) state_d = ST_SETUP;
         ST_SETUP: if (tmr == SETUP_LAST) state_d = ST_SHIFT;
         ST_SHIFT: if (frame_end) state_d = ST_HOLD;
         ST_HOLD:  if (tmr == HOLD_LAST) state_d = ST_GAP;
         ST_GAP:   if (tmr == IDLE_LAST) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state     <= ST_IDLE;
         tmr       <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         wdata_q   <= '0;
         rw_q      <= 1'b0;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         rsp_rdata <= '0;
      end else begin
         state <= state_d;
         tmr   <= (state_d != state) ? 16'd0 : tmr + 16'd1;
         if (state == ST_IDLE && cmd_valid) begin
            rw_q     <= cmd_rw;
            wdata_q  <= cmd_wdata;
            tx_sr    <= addr_byte(cmd_addr, cmd_rw);
            bit_cnt  <= '0;
            byte_cnt <= '0;
         end
         if (sck_rise) rx_sr <= {rx_sr[6:0], spi_miso};
         // Byte boundary reloads the shifter on the same falling edge
         if (sck_fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt != 3'd7) begin
               tx_sr <= {tx_sr[6:0], 1'b0};
            end else if (byte_cnt == last_byte) begin
               tx_sr <= '0;
            end else begin
               byte_cnt <= byte_cnt + 2'd1;
               tx_sr    <= (byte_cnt == 2'd0 && !rw_q) ? wdata_q : DUMMY_BYTE;
            end
         end
         if (state == ST_HOLD && state_d == ST_GAP)
            rsp_rdata <= rw_q ? rx_sr : 8'h00;
      end
   end

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = !cmd_ready;
   assign rsp_valid = (state == ST_GAP) && (tmr == 16'd0);
   assign spi_cs_n  = !(state inside {ST_SETUP, ST_SHIFT, ST_HOLD});
   assign spi_mosi  = tx_sr[7];

`ifdef SPI_MFRC522_TXN_COUNT_EN
   logic [15:0] txn_q;

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) txn_q <= '0;
      else if (rsp_valid) txn_q <= txn_q + 16'd1;
   end

   assign txn_count = txn_q;
`else
   assign txn_count = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_mfrc522_master.sv
// Scoreboard bench for spi_mfrc522_master with a behavioural
// MFRC522-like slave shared by a default and a fast-clock instance.
module tb_spi_mfrc522_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        cmd_valid0 = 1'b0, cmd_valid1 = 1'b0;
   logic        cmd_rw = 1'b0;
   logic [6:0]  cmd_addr = '0;
   logic [7:0]  cmd_wdata = '0;
   logic        miso = 1'b1;

   logic        rdy0, rv0, busy0, cs0, sck0, mosi0;
   logic        rdy1, rv1, busy1, cs1, sck1, mosi1;
   logic [7:0]  rd0, rd1;
   logic [15:0] txn0, txn1;

   spi_mfrc522_master dut (
      .axi_aclk (clk), .axi_areset (rst),
      .cmd_valid (cmd_valid0), .cmd_ready (rdy0),
      .cmd_rw (cmd_rw), .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
      .rsp_valid (rv0), .rsp_rdata (rd0), .busy (busy0),
      .txn_count (txn0), .spi_cs_n (cs0), .spi_sck (sck0),
      .spi_mosi (mosi0), .spi_miso (miso)
   );

   spi_mfrc522_master #(.CLK_DIV (1), .CS_SETUP (1)) dut1 (
      .axi_aclk (clk), .axi_areset (rst),
      .cmd_valid (cmd_valid1), .cmd_ready (rdy1),
      .cmd_rw (cmd_rw), .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
      .rsp_valid (rv1), .rsp_rdata (rd1), .busy (busy1),
      .txn_count (txn1), .spi_cs_n (cs1), .spi_sck (sck1),
      .spi_mosi (mosi1), .spi_miso (miso)
   );

   bit   sel = 1'b0;
   logic cs_m, sck_m, mosi_m;
   assign cs_m   = sel ? cs1 : cs0;
   assign sck_m  = sel ? sck1 : sck0;
   assign mosi_m = sel ? mosi1 : mosi0;

   // Slave model: MFRC522 register file, {addr,rw} first byte, data in byte 2
   logic [7:0] mem [128];
   logic [7:0] sh, cap [3], tmp;
   int         nb = 0, ncap = 0;

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[0] = 8'h93; mem[1] = 8'h20; mem[2] = 8'h55; mem[3] = 8'hAA;
      mem[7'h37] = 8'h92;
      for (int i = 0; i < 3; i++) cap[i] = 8'h00;
   end

   always @(negedge cs_m) begin nb = 0; ncap = 0; miso = 1'b1; end
   always @(posedge cs_m) begin nb = 0; miso = 1'b1; end

   always @(posedge sck_m) if (!cs_m && nb < 24) begin
      sh = {sh[6:0], mosi_m};
      nb++;
      if (nb % 8 == 0) begin
         cap[nb/8 - 1] = sh;
         ncap = nb / 8;
         if (nb == 16 && !cap[0][0]) mem[cap[0][7:1]] = cap[1];
      end
   end

   always @(negedge sck_m) if (!cs_m) begin
      if (nb >= 16 && nb < 24 && cap[0][0]) begin
         tmp  = mem[cap[0][7:1]];
         miso = tmp[23 - nb];
      end else begin
         miso = 1'b1;
      end
   end

   typedef struct {
      logic [7:0] rdata;
      logic [7:0] b0, b1, b2;
      int         nbytes;
      int         lat;
      int         acc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_vec = 0, n_bad = 0;
   int   exp_txn = 0;
   int   run = 0;
   bit   seen_rsp = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per rsp_valid from either DUT
   always @(negedge clk) begin
      if (rv0 || rv1) begin
         if (q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d, expected none", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_rdata", sel ? rd1 : rd0, e.rdata);
            chk("latency", cyc - e.acc, e.lat);
            chk("cs_n_at_rsp", cs_m, 1);
            chk("nbytes", ncap, e.nbytes);
            chk("mosi_b0", cap[0], e.b0);
            chk("mosi_b1", cap[1], e.b1);
            if (e.nbytes == 3) chk("mosi_b2", cap[2], e.b2);
         end
         seen_rsp = 1'b1;
      end
      if (cs_m) begin
         run++;
      end else begin
         if (run > 0 && seen_rsp) chk("cs_idle_gap_ge4", run >= 4, 1);
         run = 0;
      end
   end

   task automatic issue(input bit d, input bit rw, input logic [6:0] a,
                        input logic [7:0] wd, input logic [7:0] erd,
                        input int lat, input bit keep);
      exp_t e;
      int   guard;
      guard = 0;
      @(negedge clk);
      cmd_rw = rw; cmd_addr = a; cmd_wdata = wd;
      if (d) cmd_valid1 = 1'b1; else cmd_valid0 = 1'b1;
      while (!(d ? rdy1 : rdy0)) begin
         @(negedge clk);
         guard++;
         if (guard > 2000) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got no cmd_ready, expected ready within 2000 cycles");
            cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
            return;
         end
      end
      e.acc = cyc;
      e.rdata = erd;
      e.b0 = {a, rw};
      e.b1 = rw ? 8'h00 : wd;
      e.b2 = 8'h00;
      e.nbytes = rw ? 3 : 2;
      e.lat = lat;
      q.push_back(e);
      exp_txn++;
      if (!keep) begin
         @(negedge clk);
         cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q.size() != 0 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
         q.delete();
      end
      repeat (8) @(negedge clk);
   endtask

   function automatic int txn_req();
`ifdef SPI_MFRC522_TXN_COUNT_EN
      return exp_txn;
`else
      return 0;
`endif
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish before 400000 ns");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", cs0, 1);
      chk("rst_sck", sck0, 0);
      chk("rst_mosi", mosi0, 0);
      chk("rst_ready", rdy0, 1);
      chk("rst_rsp_valid", rv0, 0);
      chk("rst_rdata", rd0, 8'h00);
      chk("rst_busy", busy0, 0);
      chk("rst_txn", txn0, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      issue(0, 1, 7'h00, 8'h00, 8'h93, 197, 1);
      issue(0, 1, 7'h01, 8'h00, 8'h20, 197, 1);
      issue(0, 1, 7'h02, 8'h00, 8'h55, 197, 1);
      issue(0, 1, 7'h03, 8'h00, 8'hAA, 197, 0);
      drain();
      chk("txn_after_b2b", txn0, txn_req());

      issue(0, 0, 7'h01, 8'h0F, 8'h00, 133, 0);
      drain();
      issue(0, 1, 7'h01, 8'h00, 8'h0F, 197, 0);
      issue(0, 1, 7'h37, 8'h00, 8'h92, 197, 0);
      drain();

      issue(0, 1, 7'h37, 8'h00, 8'h92, 197, 0);
      repeat (50) @(negedge clk);
      chk("busy_mid", busy0, 1);
      chk("ready_mid", rdy0, 0);
      cmd_rw = 1'b0; cmd_addr = 7'h05; cmd_wdata = 8'hFF;
      cmd_valid0 = 1'b1;
      @(negedge clk);
      cmd_valid0 = 1'b0;
      drain();
      chk("txn_after_ignored", txn0, txn_req());

      issue(0, 1, 7'h37, 8'h00, 8'h92, 197, 0);
      guard = 0;
      while (nb < 10 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      chk("reached_byte1", nb >= 10 && nb < 16, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_cs_n", cs0, 1);
      chk("arst_sck", sck0, 0);
      chk("arst_mosi", mosi0, 0);
      chk("arst_rsp_valid", rv0, 0);
      chk("arst_ready", rdy0, 1);
      q.delete();
      exp_txn = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("arst_txn", txn0, 0);
      chk("arst_rdata", rd0, 8'h00);
      repeat (4) @(negedge clk);
      issue(0, 1, 7'h37, 8'h00, 8'h92, 197, 0);
      drain();
      chk("txn_after_reset", txn0, txn_req());

      sel = 1'b1;
      exp_txn = 0;
      repeat (4) @(negedge clk);
      issue(1, 1, 7'h37, 8'h00, 8'h92, 52, 0);
      issue(1, 1, 7'h00, 8'h00, 8'h93, 52, 0);
      drain();
      chk("txn_fast", txn1, txn_req());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
